// File: rtl/sub_pkg.sv
// Shared types for the chunked subtractor: FSM state encoding and index-width helper.
package sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } sub_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder cell; purely combinational, no handshake.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sub_chunked_seq.sv
// Multi-cycle a - b - bin, K bits per clock; done pulses N/K cycles after an accepted start.
// start is only taken while ready is high; requests while busy are dropped, not queued.
module sub_chunked_seq
  import sub_pkg::*;
#(
  parameter int N = 64,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int NCHUNK = N / K;
  localparam int IW     = idx_width(NCHUNK);

  sub_state_t   r_state;
  sub_state_t   w_state_nxt;
  logic         w_ready;
  logic         w_done;
  logic         w_accept;
  logic         w_last;

  logic [N-1:0]  r_a_sh;
  logic [N-1:0]  r_b_sh;
  logic [N-1:0]  r_diff_sh;
  logic          r_carry;
  logic          r_a_sign;
  logic          r_b_sign;
  logic [IW-1:0] r_idx;
  logic [N-1:0]  r_diff;
  logic          r_bout;
  logic          r_ovf;

  logic [K:0]    w_c;
  logic [K-1:0]  w_sum;
  logic [N-1:0]  w_diff_nxt;

  // Chunk carry enters only from the registered carry, never combinationally across cycles.
  assign w_c[0] = r_carry;

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_fa
      full_adder_1bit u_fa (
        .a    (r_a_sh[gi]),
        .b    (r_b_sh[gi]),
        .cin  (w_c[gi]),
        .sum  (w_sum[gi]),
        .cout (w_c[gi+1])
      );
    end
    if (K == N) begin : g_single
      assign w_diff_nxt = w_sum;
    end else begin : g_multi
      assign w_diff_nxt = {w_sum, r_diff_sh[N-1:K]};
    end
  endgenerate

  assign w_last = (r_idx == IW'(NCHUNK - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_diff_sh <= '0;
      r_carry   <= 1'b0;
      r_a_sign  <= 1'b0;
      r_b_sign  <= 1'b0;
      r_idx     <= '0;
      r_diff    <= '0;
      r_bout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      // Subtraction as a + ~b + ~bin.
      r_a_sh   <= a;
      r_b_sh   <= ~b;
      r_carry  <= ~bin;
      r_a_sign <= a[N-1];
      r_b_sign <= b[N-1];
      r_idx    <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh    <= r_a_sh >> K;
      r_b_sh    <= r_b_sh >> K;
      r_diff_sh <= w_diff_nxt;
      r_carry   <= w_c[K];
      r_idx     <= r_idx + IW'(1);
      if (w_last) begin
        r_diff <= w_diff_nxt;
        r_bout <= ~w_c[K];
        r_ovf  <= (r_a_sign != r_b_sign) && (w_diff_nxt[N-1] != r_a_sign);
      end
    end
  end

  assign ready = w_ready;
  assign done  = w_done;
  assign diff  = r_diff;
  assign bout  = r_bout;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_sub_chunked_seq.sv
// Directed self-checking bench for sub_chunked_seq at K=8, K=1 and K=64 (N=64).
module tb_sub_chunked_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;

  logic        ready0, done0, bout0, ovf0;
  logic [63:0] diff0;
  logic        ready1, done1, bout1, ovf1;
  logic [63:0] diff1;
  logic        ready2, done2, bout2, ovf2;
  logic [63:0] diff2;

  int checks = 0;
  int errors = 0;

  sub_chunked_seq #(.N(64), .K(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready0), .done(done0), .diff(diff0), .bout(bout0), .ovf(ovf0)
  );

  sub_chunked_seq #(.N(64), .K(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
  );

  sub_chunked_seq #(.N(64), .K(64)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rdy(input int s);
    case (s)
      1:       return ready1;
      2:       return ready2;
      default: return ready0;
    endcase
  endfunction

  function automatic logic dn(input int s);
    case (s)
      1:       return done1;
      2:       return done2;
      default: return done0;
    endcase
  endfunction

  function automatic logic [65:0] res(input int s);
    case (s)
      1:       return {diff1, bout1, ovf1};
      2:       return {diff2, bout2, ovf2};
      default: return {diff0, bout0, ovf0};
    endcase
  endfunction

  // Launches one operation on the selected instance and measures start-to-done latency.
  task automatic run_op(input int sel, input logic [63:0] ia, input logic [63:0] ib,
                        input logic ibin, output int lat, output logic [63:0] od,
                        output logic obo, output logic oov, output logic pulse_ok);
    logic [65:0] r;
    int n;
    n = 0;
    while (!rdy(sel) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int e = 1; e <= 300; e++) begin
      @(posedge clk); #1;
      if (dn(sel)) begin
        lat = e;
        break;
      end
    end
    r = res(sel);
    od = r[65:2]; obo = r[1]; oov = r[0];
    @(posedge clk); #1;
    pulse_ok = !dn(sel) && rdy(sel);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready0 !== 1'b1 || done0 !== 1'b0) begin
      errors++; $display("FAIL reset_hs: ready=%b done=%b, want ready=1 done=0", ready0, done0);
    end
    checks++;
    if (diff0 !== 64'd0 || bout0 !== 1'b0 || ovf0 !== 1'b0) begin
      errors++; $display("FAIL reset_out: diff=%h bout=%b ovf=%b, want 0/0/0", diff0, bout0, ovf0);
    end
    checks++;
    if (ready1 !== 1'b1 || ready2 !== 1'b1) begin
      errors++; $display("FAIL reset_ready_k1_k64: got %b %b, want 1 1", ready1, ready2);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [63:0] d; logic bo, ov, pk;
    run_op(0, 64'd5, 64'd3, 1'b0, lat, d, bo, ov, pk);
    checks++;
    if (d !== 64'd2 || bo !== 1'b0 || ov !== 1'b0) begin
      errors++; $display("FAIL basic_5m3: diff=%h bout=%b ovf=%b, want 2/0/0", d, bo, ov);
    end
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL basic_latency: got %0d, want 8", lat);
    end
    checks++;
    if (pk !== 1'b1) begin
      errors++; $display("FAIL basic_done_pulse: done not a single-cycle pulse followed by ready");
    end
  endtask

  task automatic test_borrow_ovf();
    int lat; logic [63:0] d; logic bo, ov, pk;
    run_op(0, 64'd0, 64'd1, 1'b0, lat, d, bo, ov, pk);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF || bo !== 1'b1 || ov !== 1'b0) begin
      errors++; $display("FAIL borrow_0m1: diff=%h bout=%b ovf=%b, want ffffffffffffffff/1/0", d, bo, ov);
    end
    run_op(0, 64'h8000_0000_0000_0000, 64'd1, 1'b0, lat, d, bo, ov, pk);
    checks++;
    if (d !== 64'h7FFF_FFFF_FFFF_FFFF || bo !== 1'b0 || ov !== 1'b1) begin
      errors++; $display("FAIL ovf_min_m1: diff=%h bout=%b ovf=%b, want 7fffffffffffffff/0/1", d, bo, ov);
    end
    run_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat, d, bo, ov, pk);
    checks++;
    if (d !== 64'h8000_0000_0000_0000 || bo !== 1'b1 || ov !== 1'b1) begin
      errors++; $display("FAIL ovf_max_mneg1: diff=%h bout=%b ovf=%b, want 8000000000000000/1/1", d, bo, ov);
    end
  endtask

  task automatic test_cross_chunk();
    int lat; logic [63:0] d; logic bo, ov, pk;
    run_op(0, 64'h100, 64'd1, 1'b0, lat, d, bo, ov, pk);
    checks++;
    if (d !== 64'hFF || bo !== 1'b0) begin
      errors++; $display("FAIL cross_chunk: diff=%h bout=%b, want ff/0", d, bo);
    end
    run_op(0, 64'd10, 64'd3, 1'b1, lat, d, bo, ov, pk);
    checks++;
    if (d !== 64'd6 || bo !== 1'b0) begin
      errors++; $display("FAIL bin_10m3m1: diff=%h bout=%b, want 6/0", d, bo);
    end
  endtask

  task automatic test_back_to_back();
    int low; logic [63:0] first_d; logic saw_done; int lat;
    while (!ready0) begin @(posedge clk); #1; end
    a = 64'd20; b = 64'd5; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    low = 0; saw_done = 1'b0; first_d = '0;
    for (int i = 0; i < 40 && !ready0; i++) begin
      low++;
      if (done0) begin saw_done = 1'b1; first_d = diff0; end
      a = 64'd100 + 64'(i); b = 64'(i);
      @(posedge clk); #1;
    end
    checks++;
    if (low !== 9) begin
      errors++; $display("FAIL busy_ready_low: got %0d cycles, want 9", low);
    end
    checks++;
    if (!saw_done || first_d !== 64'd15) begin
      errors++; $display("FAIL busy_first_only: done=%b diff=%h, want 1/f", saw_done, first_d);
    end
    a = 64'd50; b = 64'd8;
    @(posedge clk); #1;
    start = 1'b0; a = 64'd999; b = 64'd1;
    lat = -1;
    for (int e = 1; e <= 50; e++) begin
      @(posedge clk); #1;
      if (done0) begin lat = e; break; end
    end
    checks++;
    if (lat !== 8 || diff0 !== 64'd42) begin
      errors++; $display("FAIL second_request: lat=%0d diff=%h, want 8/2a", lat, diff0);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] d; logic bo, ov, pk;
    while (!ready0) begin @(posedge clk); #1; end
    a = 64'd5; b = 64'd3; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (ready0 !== 1'b1 || done0 !== 1'b0 || diff0 !== 64'd0 || bout0 !== 1'b0 || ovf0 !== 1'b0) begin
      errors++; $display("FAIL mid_reset: ready=%b done=%b diff=%h bout=%b ovf=%b, want 1/0/0/0/0",
                         ready0, done0, diff0, bout0, ovf0);
    end
    run_op(0, 64'd9, 64'd4, 1'b0, lat, d, bo, ov, pk);
    checks++;
    if (d !== 64'd5 || lat !== 8) begin
      errors++; $display("FAIL after_reset_op: diff=%h lat=%0d, want 5/8", d, lat);
    end
  endtask

  task automatic test_k_corners();
    int lat; logic [63:0] d; logic bo, ov, pk;
    run_op(1, 64'd5, 64'd3, 1'b0, lat, d, bo, ov, pk);
    checks++;
    if (d !== 64'd2 || bo !== 1'b0 || lat !== 64 || pk !== 1'b1) begin
      errors++; $display("FAIL k1_serial: diff=%h bout=%b lat=%0d pulse=%b, want 2/0/64/1", d, bo, lat, pk);
    end
    run_op(2, 64'd5, 64'd3, 1'b0, lat, d, bo, ov, pk);
    checks++;
    if (d !== 64'd2 || bo !== 1'b0 || lat !== 1 || pk !== 1'b1) begin
      errors++; $display("FAIL k64_single: diff=%h bout=%b lat=%0d pulse=%b, want 2/0/1/1", d, bo, lat, pk);
    end
    run_op(2, 64'h8000_0000_0000_0000, 64'd1, 1'b0, lat, d, bo, ov, pk);
    checks++;
    if (d !== 64'h7FFF_FFFF_FFFF_FFFF || bo !== 1'b0 || ov !== 1'b1) begin
      errors++; $display("FAIL k64_ovf: diff=%h bout=%b ovf=%b, want 7fffffffffffffff/0/1", d, bo, ov);
    end
    run_op(1, 64'd0, 64'd1, 1'b0, lat, d, bo, ov, pk);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF || bo !== 1'b1 || ov !== 1'b0) begin
      errors++; $display("FAIL k1_borrow: diff=%h bout=%b ovf=%b, want ffffffffffffffff/1/0", d, bo, ov);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_ovf();
    test_cross_chunk();
    test_back_to_back();
    test_reset_mid();
    test_k_corners();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
